// File: rtl/hms_pkg.sv
// Shared HMS timekeeper definitions: field codes, field limits and 7-segment patterns.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package hms_pkg;

  typedef enum logic [1:0] {
    FLD_NONE = 2'd0,
    FLD_SEC  = 2'd1,
    FLD_MIN  = 2'd2,
    FLD_HRS  = 2'd3
  } fld_e;

  // Limits are 6 bits wide so that 59 is representable.
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] HRS_MAX = 6'd23;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  function automatic logic [6:0] seg_of(input logic [5:0] d);
    case (d)
      6'd0:    seg_of = SEG_0;
      6'd1:    seg_of = SEG_1;
      6'd2:    seg_of = SEG_2;
      6'd3:    seg_of = SEG_3;
      6'd4:    seg_of = SEG_4;
      6'd5:    seg_of = SEG_5;
      6'd6:    seg_of = SEG_6;
      6'd7:    seg_of = SEG_7;
      6'd8:    seg_of = SEG_8;
      6'd9:    seg_of = SEG_9;
      default: seg_of = SEG_DASH;
    endcase
  endfunction

  function automatic fld_e fld_of_idx(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: fld_of_idx = FLD_SEC;
      3'd2, 3'd3: fld_of_idx = FLD_MIN;
      3'd4, 3'd5: fld_of_idx = FLD_HRS;
      default:    fld_of_idx = FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hms_bcd_seg.sv
// Splits a time field into tens/ones 7-segment patterns; values above the
// limit show a dash on both digits.
module hms_bcd_seg
  import hms_pkg::*;
(
  input  logic [5:0] val_i,
  input  logic [5:0] lim_i,
  output logic [6:0] tens_o,
  output logic [6:0] ones_o
);

  logic [5:0] tens_s;
  logic [5:0] ones_s;

  // decimal split and dash substitution
  always_comb begin
    tens_s = val_i / 6'd10;
    ones_s = val_i % 6'd10;
    if (val_i > lim_i) begin
      tens_o = SEG_DASH;
      ones_o = SEG_DASH;
    end else begin
      tens_o = seg_of(tens_s);
      ones_o = seg_of(ones_s);
    end
  end

endmodule

// File: rtl/hms_disp_scan.sv
// Six-digit multiplexed 7-segment scanner for the HMS timekeeper with a
// per-frame input snapshot and blinking of the field being edited.
module hms_disp_scan
  import hms_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [1:0] blink_field,
  output logic [6:0] seg,
  output logic [5:0] an
);

  localparam int CW = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          frame_start_s;
  logic [4:0]    hrs_q, hrs_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [BW-1:0] bc_q, bc_d;
  logic          ph_q, ph_d;
  logic [1:0]    bf_q;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic [6:0]    sec_t_s, sec_o_s, min_t_s, min_o_s, hrs_t_s, hrs_o_s;

  // scan position; the first edge after reset is treated as a frame start
  always_comb begin
    run_d         = 1'b1;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    frame_start_s = 1'b0;
    if (!run_q) begin
      cnt_d         = '0;
      idx_d         = 3'd0;
      frame_start_s = 1'b1;
    end else if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      if (idx_q == 3'd5) begin
        idx_d         = 3'd0;
        frame_start_s = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // snapshot bypass so the frame-start edge already shows the new values
  always_comb begin
    if (frame_start_s) begin
      hrs_d = hrs;
      min_d = min;
      sec_d = sec;
    end else begin
      hrs_d = hrs_q;
      min_d = min_q;
      sec_d = sec_q;
    end
  end

  hms_bcd_seg u_sec (.val_i(sec_d),         .lim_i(SEC_MAX), .tens_o(sec_t_s), .ones_o(sec_o_s));
  hms_bcd_seg u_min (.val_i(min_d),         .lim_i(MIN_MAX), .tens_o(min_t_s), .ones_o(min_o_s));
  hms_bcd_seg u_hrs (.val_i({1'b0, hrs_d}), .lim_i(HRS_MAX), .tens_o(hrs_t_s), .ones_o(hrs_o_s));

  // blink phase; a field change wins over a coincident wrap
  always_comb begin
    if (blink_field != bf_q) begin
      bc_d = '0;
      ph_d = 1'b0;
    end else if (bc_q == BW'(BLINK_DIV - 1)) begin
      bc_d = '0;
      ph_d = ~ph_q;
    end else begin
      bc_d = bc_q + BW'(1);
      ph_d = ph_q;
    end
  end

  // digit mux and enable with blanking of the edited field
  always_comb begin
    case (idx_d)
      3'd0:    seg_d = sec_o_s;
      3'd1:    seg_d = sec_t_s;
      3'd2:    seg_d = min_o_s;
      3'd3:    seg_d = min_t_s;
      3'd4:    seg_d = hrs_o_s;
      3'd5:    seg_d = hrs_t_s;
      default: seg_d = 7'd0;
    endcase
    if ((blink_field != FLD_NONE) && ph_d && (blink_field == fld_of_idx(idx_d))) begin
      an_d = 6'd0;
    end else begin
      an_d = 6'd1 << idx_d;
    end
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= 3'd0;
      hrs_q <= 5'd0;
      min_q <= 6'd0;
      sec_q <= 6'd0;
      bc_q  <= '0;
      ph_q  <= 1'b0;
      bf_q  <= 2'd0;
      seg_q <= 7'd0;
      an_q  <= 6'd0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      hrs_q <= hrs_d;
      min_q <= min_d;
      sec_q <= sec_d;
      bc_q  <= bc_d;
      ph_q  <= ph_d;
      bf_q  <= blink_field;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_hms_disp_scan.sv
// Bench for hms_disp_scan (SCAN_DIV=4, BLINK_DIV=8): frame-position reference
// model, pattern tables and hand-written reset/snapshot/blink sequences.
module tb_hms_disp_scan;

  localparam int SD = 4;
  localparam int BD = 8;
  localparam int FRAME = 6 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] h_in = 5'd0;
  logic [5:0] m_in = 6'd0;
  logic [5:0] s_in = 6'd0;
  logic [1:0] bf_in = 2'd0;
  logic [6:0] seg;
  logic [5:0] an;

  int checks = 0;
  int errors = 0;

  hms_disp_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .hrs(h_in), .min(m_in), .sec(s_in),
    .blink_field(bf_in), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  logic [6:0] pat [0:10];
  int m_n, m_e, m_k;
  int m_bfq;
  int sh_h, sh_m, sh_s;

  typedef struct {
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic [41:0] exp;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int k);
    int v, lim, d;
    case (k / 2)
      0:       begin v = sh_s; lim = 59; end
      1:       begin v = sh_m; lim = 59; end
      default: begin v = sh_h; lim = 23; end
    endcase
    if (v > lim) return pat[10];
    d = (k % 2 == 1) ? v / 10 : v % 10;
    return pat[d];
  endfunction

  task automatic model_reset();
    m_n = 0; m_e = 0; m_bfq = 0; m_k = 0;
  endtask

  // one clock edge: advance the model, compare both outputs
  task automatic tick();
    int ih, im, is, ib, pos;
    logic [6:0] exp_an;
    ih = h_in; im = m_in; is = s_in; ib = bf_in;
    @(posedge clk);
    #1;
    if (ib != m_bfq) begin m_e = 0; m_bfq = ib; end
    else m_e++;
    pos = m_n % FRAME;
    if (pos == 0) begin sh_h = ih; sh_m = im; sh_s = is; end
    m_k = pos / SD;
    m_n++;
    exp_an = 7'd1 << m_k;
    if (ib != 0 && ((m_e / BD) % 2 == 1) && (m_k / 2 + 1) == ib) exp_an = 7'd0;
    chk("model_an", {1'b0, an}, exp_an);
    chk("model_seg", seg, model_seg(m_k));
  endtask

  task automatic to_frame_start();
    while (m_n % FRAME != 0) tick();
  endtask

  initial begin
    int zeros;
    logic [41:0] e;
    pat[0] = 7'b0111111; pat[1] = 7'b0000110; pat[2] = 7'b1011011;
    pat[3] = 7'b1001111; pat[4] = 7'b1100110; pat[5] = 7'b1101101;
    pat[6] = 7'b1111101; pat[7] = 7'b0000111; pat[8] = 7'b1111111;
    pat[9] = 7'b1101111; pat[10] = 7'b1000000;

    // slot order in exp: {slot5, slot4, slot3, slot2, slot1, slot0}
    tbl[0] = '{5'd12, 6'd34, 6'd56, {7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110, 7'b1101101, 7'b1111101}};
    tbl[1] = '{5'd24, 6'd61, 6'd0,  {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b0111111, 7'b0111111}};
    tbl[2] = '{5'd23, 6'd59, 6'd59, {7'b1011011, 7'b1001111, 7'b1101101, 7'b1101111, 7'b1101101, 7'b1101111}};
    tbl[3] = '{5'd5,  6'd7,  6'd0,  {7'b0111111, 7'b1101101, 7'b0111111, 7'b0000111, 7'b0111111, 7'b0111111}};

    // reset state
    h_in = 5'd12; m_in = 6'd34; s_in = 6'd56; bf_in = 2'd0;
    #12;
    chk("reset_an", {1'b0, an}, 7'd0);
    chk("reset_seg", seg, 7'd0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    tick();
    chk("first_an", {1'b0, an}, 7'b0000001);
    chk("first_seg", seg, 7'b1111101);

    // scan order / out-of-range / wrap boundaries / leading zero
    for (int v = 0; v < 4; v++) begin
      h_in = tbl[v].h; m_in = tbl[v].m; s_in = tbl[v].s;
      e = tbl[v].exp;
      to_frame_start();
      for (int c = 0; c < FRAME; c++) begin
        tick();
        chk($sformatf("tbl%0d_an_c%0d", v, c), {1'b0, an}, 7'd1 << (c / SD));
        chk($sformatf("tbl%0d_seg_c%0d", v, c), seg, e[(c / SD) * 7 +: 7]);
      end
    end

    // snapshot: sec change during digit 3 waits for the next frame
    h_in = 5'd12; m_in = 6'd34; s_in = 6'd56;
    to_frame_start();
    for (int c = 0; c < 3 * SD + 1; c++) tick();
    s_in = 6'd7;
    while (m_n % FRAME != 0) tick();
    tick();
    chk("snap_ones_an", {1'b0, an}, 7'b0000001);
    chk("snap_ones", seg, 7'b0000111);
    for (int c = 0; c < SD; c++) tick();
    chk("snap_tens", seg, 7'b0111111);

    // blink minutes, then switch to hours
    s_in = 6'd56;
    bf_in = 2'd2;
    zeros = 0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (an == 6'd0) zeros++;
    end
    checks++;
    if (zeros == 0) begin
      errors++;
      $display("FAIL blink_min_blanked actual=%0d expected=nonzero", zeros);
    end
    bf_in = 2'd3;
    for (int c = 0; c < BD; c++) begin
      tick();
      chk("blink_switch_visible", {1'b0, an == 6'd0}, 7'd0);
    end
    for (int c = 0; c < 40; c++) tick();
    bf_in = 2'd0;
    for (int c = 0; c < 24; c++) tick();

    // asynchronous reset mid-frame
    to_frame_start();
    for (int c = 0; c < 9; c++) tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_an", {1'b0, an}, 7'd0);
    chk("midrst_seg", seg, 7'd0);
    s_in = 6'd41;
    @(negedge clk); rst = 1'b0;
    model_reset();
    tick();
    chk("rerun_an", {1'b0, an}, 7'b0000001);
    chk("rerun_seg", seg, 7'b0000110);

    // randomized inputs against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) h_in = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) m_in = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) s_in = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) bf_in = 2'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
